// File: rtl/control_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : control_sequencer
// Desc     : Moore control sequencer driving the 32-bit datapath strobes through
//            fetch (T0-T2) and execute (T3-T7). Optional macro MEM_WAIT_EN adds
//            a mem_ready port that stretches the memory-access states.
// Revision : 1.0 - initial release
// =============================================================================
module control_sequencer #(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic [31:0]         IR,
    input  logic                CON_FF,
`ifdef MEM_WAIT_EN
    input  logic                mem_ready,
`endif
    output logic                PCout,
    output logic                ZLowout,
    output logic                MDRout,
    output logic                BAout,
    output logic                Cout,
    output logic                R_out,
    output logic                MAR_enable,
    output logic                MDR_enable,
    output logic                MDR_read,
    output logic                IR_enable,
    output logic                Y_enable,
    output logic                ZLowIn,
    output logic                PC_enable,
    output logic                R_in,
    output logic                IncPC,
    output logic                CON_enable,
    output logic                RAM_write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run
);

    localparam logic [OPCODE_W-1:0] c_OP_LD   = OPCODE_W'(5'b00000);
    localparam logic [OPCODE_W-1:0] c_OP_ST   = OPCODE_W'(5'b00010);
    localparam logic [OPCODE_W-1:0] c_OP_ADD  = OPCODE_W'(5'b00011);
    localparam logic [OPCODE_W-1:0] c_OP_SUB  = OPCODE_W'(5'b00100);
    localparam logic [OPCODE_W-1:0] c_OP_AND  = OPCODE_W'(5'b00101);
    localparam logic [OPCODE_W-1:0] c_OP_OR   = OPCODE_W'(5'b00110);
    localparam logic [OPCODE_W-1:0] c_OP_ADDI = OPCODE_W'(5'b01011);
    localparam logic [OPCODE_W-1:0] c_OP_BR   = OPCODE_W'(5'b10011);
    localparam logic [OPCODE_W-1:0] c_OP_JR   = OPCODE_W'(5'b10100);
    localparam logic [OPCODE_W-1:0] c_OP_HALT = OPCODE_W'(5'b11011);

    typedef enum logic [3:0] {
        S_T0     = 4'd0,
        S_T1     = 4'd1,
        S_T2     = 4'd2,
        S_T3     = 4'd3,
        S_T4     = 4'd4,
        S_T5     = 4'd5,
        S_T6     = 4'd6,
        S_T7     = 4'd7,
        S_HALTED = 4'd8
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OPCODE_W-1:0] w_op;
    logic                w_unused_ir;
    logic                w_mem_ok;
    logic                w_is_ld;
    logic                w_is_st;
    logic                w_is_mem;
    logic                w_is_rtype;
    logic                w_is_addi;
    logic                w_is_br;
    logic                w_is_jr;

    assign w_op        = IR[31 -: OPCODE_W];
    assign w_unused_ir = ^IR[31-OPCODE_W:0];

`ifdef MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    assign w_is_ld    = (w_op == c_OP_LD);
    assign w_is_st    = (w_op == c_OP_ST);
    assign w_is_mem   = w_is_ld | w_is_st;
    assign w_is_rtype = (w_op == c_OP_ADD) | (w_op == c_OP_SUB) |
                        (w_op == c_OP_AND) | (w_op == c_OP_OR);
    assign w_is_addi  = (w_op == c_OP_ADDI);
    assign w_is_br    = (w_op == c_OP_BR);
    assign w_is_jr    = (w_op == c_OP_JR);

    // Memory states (T1, ld T6, st T7) hold until the memory reports done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: if (w_mem_ok) state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                if (w_op == c_OP_HALT)
                    state_d = S_HALTED;
                else if (w_is_mem | w_is_rtype | w_is_addi | w_is_br)
                    state_d = S_T4;
                else
                    state_d = S_T0;
            end
            S_T4: state_d = S_T5;
            S_T5: state_d = (w_is_mem | w_is_br) ? S_T6 : S_T0;
            S_T6: begin
                if (w_is_st)
                    state_d = S_T7;
                else if (w_is_ld) begin
                    if (w_mem_ok) state_d = S_T7;
                end else
                    state_d = S_T0;
            end
            S_T7: if (!w_is_st || w_mem_ok) state_d = S_T0;
            S_HALTED: state_d = S_HALTED;
            default: state_d = S_T0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear)
            state_q <= S_T0;
        else
            state_q <= state_d;
    end

    // Strobes decode from state and opcode; Clear blanks everything immediately.
    always_comb begin
        PCout      = 1'b0;
        ZLowout    = 1'b0;
        MDRout     = 1'b0;
        BAout      = 1'b0;
        Cout       = 1'b0;
        R_out      = 1'b0;
        MAR_enable = 1'b0;
        MDR_enable = 1'b0;
        MDR_read   = 1'b0;
        IR_enable  = 1'b0;
        Y_enable   = 1'b0;
        ZLowIn     = 1'b0;
        PC_enable  = 1'b0;
        R_in       = 1'b0;
        IncPC      = 1'b0;
        CON_enable = 1'b0;
        RAM_write  = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        alu_op     = '0;
        run        = 1'b0;
        if (!Clear) begin
            run = (state_q != S_HALTED);
            case (state_q)
                S_T0: begin
                    PCout      = 1'b1;
                    MAR_enable = 1'b1;
                    IncPC      = 1'b1;
                    ZLowIn     = 1'b1;
                end
                S_T1: begin
                    ZLowout    = 1'b1;
                    PC_enable  = 1'b1;
                    MDR_read   = 1'b1;
                    MDR_enable = 1'b1;
                end
                S_T2: begin
                    MDRout    = 1'b1;
                    IR_enable = 1'b1;
                end
                S_T3: begin
                    if (w_is_mem) begin
                        Grb      = 1'b1;
                        BAout    = 1'b1;
                        Y_enable = 1'b1;
                    end else if (w_is_rtype | w_is_addi) begin
                        Grb      = 1'b1;
                        R_out    = 1'b1;
                        Y_enable = 1'b1;
                    end else if (w_is_br) begin
                        Gra        = 1'b1;
                        R_out      = 1'b1;
                        CON_enable = 1'b1;
                    end else if (w_is_jr) begin
                        Gra       = 1'b1;
                        R_out     = 1'b1;
                        PC_enable = 1'b1;
                    end
                end
                S_T4: begin
                    if (w_is_mem | w_is_addi) begin
                        Cout   = 1'b1;
                        ZLowIn = 1'b1;
                        alu_op = ALU_OP_W'(c_OP_ADD);
                    end else if (w_is_rtype) begin
                        Grc    = 1'b1;
                        R_out  = 1'b1;
                        ZLowIn = 1'b1;
                        alu_op = ALU_OP_W'(w_op);
                    end else if (w_is_br) begin
                        PCout    = 1'b1;
                        Y_enable = 1'b1;
                    end
                end
                S_T5: begin
                    if (w_is_mem) begin
                        ZLowout    = 1'b1;
                        MAR_enable = 1'b1;
                    end else if (w_is_rtype | w_is_addi) begin
                        ZLowout = 1'b1;
                        Gra     = 1'b1;
                        R_in    = 1'b1;
                    end else if (w_is_br) begin
                        Cout   = 1'b1;
                        ZLowIn = 1'b1;
                        alu_op = ALU_OP_W'(c_OP_ADD);
                    end
                end
                S_T6: begin
                    if (w_is_ld) begin
                        MDR_read   = 1'b1;
                        MDR_enable = 1'b1;
                    end else if (w_is_st) begin
                        Gra        = 1'b1;
                        R_out      = 1'b1;
                        MDR_enable = 1'b1;
                    end else if (w_is_br && CON_FF) begin
                        ZLowout   = 1'b1;
                        PC_enable = 1'b1;
                    end
                end
                S_T7: begin
                    if (w_is_ld) begin
                        MDRout = 1'b1;
                        Gra    = 1'b1;
                        R_in   = 1'b1;
                    end else if (w_is_st) begin
                        RAM_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_control_sequencer
// Desc     : Directed self-checking bench for control_sequencer strobe sequences.
// Revision : 1.0 - initial release
// =============================================================================
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        CON_FF;
`ifdef MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic PCout, ZLowout, MDRout, BAout, Cout, R_out;
    logic MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable, ZLowIn, PC_enable, R_in;
    logic IncPC, CON_enable, RAM_write, Gra, Grb, Grc, run;
    logic [4:0] alu_op;

    int compared   = 0;
    int mismatched = 0;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .IR         (IR),
        .CON_FF     (CON_FF),
`ifdef MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .PCout      (PCout),
        .ZLowout    (ZLowout),
        .MDRout     (MDRout),
        .BAout      (BAout),
        .Cout       (Cout),
        .R_out      (R_out),
        .MAR_enable (MAR_enable),
        .MDR_enable (MDR_enable),
        .MDR_read   (MDR_read),
        .IR_enable  (IR_enable),
        .Y_enable   (Y_enable),
        .ZLowIn     (ZLowIn),
        .PC_enable  (PC_enable),
        .R_in       (R_in),
        .IncPC      (IncPC),
        .CON_enable (CON_enable),
        .RAM_write  (RAM_write),
        .Gra        (Gra),
        .Grb        (Grb),
        .Grc        (Grc),
        .alu_op     (alu_op),
        .run        (run)
    );

    logic [25:0] ctl;
    assign ctl = {run, alu_op, Grc, Grb, Gra, RAM_write, CON_enable, IncPC, R_in,
                  PC_enable, ZLowIn, Y_enable, IR_enable, MDR_read, MDR_enable,
                  MAR_enable, R_out, Cout, BAout, MDRout, ZLowout, PCout};

    localparam logic [25:0] PCO  = 26'd1 << 0;
    localparam logic [25:0] ZLO  = 26'd1 << 1;
    localparam logic [25:0] MDRO = 26'd1 << 2;
    localparam logic [25:0] BAO  = 26'd1 << 3;
    localparam logic [25:0] CO   = 26'd1 << 4;
    localparam logic [25:0] RO   = 26'd1 << 5;
    localparam logic [25:0] MARE = 26'd1 << 6;
    localparam logic [25:0] MDRE = 26'd1 << 7;
    localparam logic [25:0] MDRR = 26'd1 << 8;
    localparam logic [25:0] IRE  = 26'd1 << 9;
    localparam logic [25:0] YE   = 26'd1 << 10;
    localparam logic [25:0] ZLI  = 26'd1 << 11;
    localparam logic [25:0] PCE  = 26'd1 << 12;
    localparam logic [25:0] RI   = 26'd1 << 13;
    localparam logic [25:0] INC  = 26'd1 << 14;
    localparam logic [25:0] CONE = 26'd1 << 15;
    localparam logic [25:0] RAMW = 26'd1 << 16;
    localparam logic [25:0] GRA  = 26'd1 << 17;
    localparam logic [25:0] GRB  = 26'd1 << 18;
    localparam logic [25:0] GRC  = 26'd1 << 19;
    localparam logic [25:0] RUN  = 26'd1 << 25;
    localparam logic [25:0] ALU_ADD = 26'd3 << 20;
    localparam logic [25:0] ALU_SUB = 26'd4 << 20;
    localparam logic [25:0] ALU_OR  = 26'd6 << 20;

    localparam logic [25:0] E_T0 = RUN | PCO | MARE | INC | ZLI;
    localparam logic [25:0] E_T1 = RUN | ZLO | PCE | MDRR | MDRE;
    localparam logic [25:0] E_T2 = RUN | MDRO | IRE;

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [25:0] exp);
        @(posedge Clock);
        #1;
        check(tag, ctl, exp);
    endtask

    // Current cycle is already T0 (checked by the caller); walk T1 and T2.
    task automatic fetch(input string tag);
        step({tag, ".T1"}, E_T1);
        step({tag, ".T2"}, E_T2);
    endtask

    initial begin
        Clear  = 1'b1;
        IR     = 32'h0;
        CON_FF = 1'b0;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge Clock);
        #1;
        check("reset_all_zero", ctl, 26'd0);
        Clear = 1'b0;
        #1;
        check("reset_exit_T0", ctl, E_T0);

        IR = 32'h59080002;
        fetch("addi");
        step("addi.T3", RUN | GRB | RO | YE);
        step("addi.T4", RUN | CO | ZLI | ALU_ADD);
        step("addi.T5", RUN | ZLO | GRA | RI);
        step("addi.cycle7_T0", E_T0);

        IR = 32'hA0800000;
        fetch("jr");
        step("jr.T3", RUN | GRA | RO | PCE);
        step("jr.next_T0", E_T0);

        IR = 32'h00900010;
        fetch("ld");
        step("ld.T3", RUN | GRB | BAO | YE);
        step("ld.T4", RUN | CO | ZLI | ALU_ADD);
        step("ld.T5", RUN | ZLO | MARE);
        step("ld.T6", RUN | MDRR | MDRE);
        step("ld.T7", RUN | MDRO | GRA | RI);
        step("ld.next_T0", E_T0);

        IR = 32'h10900010;
        fetch("st");
        step("st.T3", RUN | GRB | BAO | YE);
        step("st.T4", RUN | CO | ZLI | ALU_ADD);
        step("st.T5", RUN | ZLO | MARE);
        step("st.T6", RUN | GRA | RO | MDRE);
        step("st.T7", RUN | RAMW);
        step("st.next_T0", E_T0);

        IR = 32'h20000000;
        fetch("sub");
        step("sub.T3", RUN | GRB | RO | YE);
        step("sub.T4", RUN | GRC | RO | ZLI | ALU_SUB);
        step("sub.T5", RUN | ZLO | GRA | RI);
        step("sub.next_T0", E_T0);

        IR = 32'h30000000;
        fetch("or");
        step("or.T3", RUN | GRB | RO | YE);
        step("or.T4", RUN | GRC | RO | ZLI | ALU_OR);
        step("or.T5", RUN | ZLO | GRA | RI);
        step("or.next_T0", E_T0);

        IR = 32'h98800008;
        CON_FF = 1'b0;
        fetch("br0");
        step("br0.T3", RUN | GRA | RO | CONE);
        step("br0.T4", RUN | PCO | YE);
        step("br0.T5", RUN | CO | ZLI | ALU_ADD);
        step("br0.T6_idle", RUN);
        step("br0.next_T0", E_T0);

        CON_FF = 1'b1;
        fetch("br1");
        step("br1.T3", RUN | GRA | RO | CONE);
        step("br1.T4", RUN | PCO | YE);
        step("br1.T5", RUN | CO | ZLI | ALU_ADD);
        step("br1.T6_taken", RUN | ZLO | PCE);
        step("br1.next_T0", E_T0);
        CON_FF = 1'b0;

        IR = 32'hD0000000;
        fetch("nop");
        step("nop.T3", RUN);
        step("nop.next_T0", E_T0);

        IR = 32'hF8000000;
        fetch("undef");
        step("undef.T3", RUN);
        step("undef.next_T0", E_T0);

`ifdef MEM_WAIT_EN
        IR = 32'hD0000000;
        mem_ready = 1'b0;
        step("wait.T1_c1", E_T1);
        step("wait.T1_c2", E_T1);
        step("wait.T1_c3", E_T1);
        step("wait.T1_c4", E_T1);
        mem_ready = 1'b1;
        step("wait.T2", E_T2);
        step("wait.T3", RUN);
        step("wait.next_T0", E_T0);
`endif

        // Store aborted by Clear in T6: the write strobe must never appear.
        IR = 32'h10900010;
        fetch("st_abort");
        step("st_abort.T3", RUN | GRB | BAO | YE);
        step("st_abort.T4", RUN | CO | ZLI | ALU_ADD);
        step("st_abort.T5", RUN | ZLO | MARE);
        step("st_abort.T6", RUN | GRA | RO | MDRE);
        Clear = 1'b1;
        #1;
        check("st_abort.clear_zero", ctl, 26'd0);
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        #1;
        check("st_abort.T0", ctl, E_T0);

        IR = 32'hD8000000;
        fetch("halt");
        step("halt.T3", RUN);
        for (int i = 0; i < 20; i++) begin
            step("halt.idle", 26'd0);
        end
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        #1;
        check("halt.clear_T0", ctl, E_T0);
        IR = 32'hD0000000;
        step("halt.restart_T1", E_T1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
